// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, sequencer encoding and flat-bus index helper for regfile_bank
//   NREG / WIDTH / AW : register count, register width, address width
//   ST_IDLE / ST_CLEAR: sequencer state encoding
//   flat_idx(k, i)    : position of bit i of register k on the flat bus
package rf_pkg;

  localparam int NREG  = 32;
  localparam int WIDTH = 32;
  localparam int AW    = 5;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  function automatic int flat_idx(input int k, input int i);
    return k * WIDTH + i;
  endfunction

endpackage

// File: rtl/regfile_bank_decoder5to32.sv
// rtl/regfile_bank_decoder5to32.sv - 5-to-32 one-hot load-enable decoder, bit 0 never asserted
//   addr   in  5   register address
//   en     in  1   enable; all outputs low when 0
//   onehot out 32  one-hot load enable, onehot[0] tied low (r0 is not storage)
module decoder5to32
  import rf_pkg::*;
(
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    onehot[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - 32x32 register storage with single write port, r0 = 0, and a clear sweeper
//   clk   in  1     rising-edge clock
//   rst_n in  1     asynchronous active-low reset: clears array, sequencer to IDLE
//   we    in  1     write enable (ignored while busy)
//   wa    in  5     write address (0 ignored)
//   wd    in  32    write data
//   clr   in  1     start a clear sweep of r1..r31 (sampled only in IDLE)
//   busy  out 1     high while the sweep runs
//   b     out 1024  flat register image, register k at b[32k+31:32k]
module regfile_bank #(
  parameter int NREG  = rf_pkg::NREG,
  parameter int WIDTH = rf_pkg::WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [4:0]            wa,
  input  logic [WIDTH-1:0]      wd,
  input  logic                  clr,
  output logic                  busy,
  output logic [NREG*WIDTH-1:0] b
);

  import rf_pkg::*;

  logic [0:0]      state;
  logic [AW-1:0]   cnt;
  logic            clearing;
  logic [AW-1:0]   dec_addr;
  logic            dec_en;
  logic [WIDTH-1:0] load_data;
  logic [NREG-1:0] load;
  logic            unused_load0;

  assign clearing = (state == ST_CLEAR);
  assign busy     = clearing;

  // One decoder serves both paths: the sweep owns it while clearing, which
  // is also what drops CPU writes during a sweep.
  assign dec_addr  = clearing ? cnt   : wa;
  assign dec_en    = clearing ? 1'b1  : we;
  assign load_data = clearing ? '0    : wd;

  decoder5to32 u_dec (
    .addr   (dec_addr),
    .en     (dec_en),
    .onehot (load)
  );

  assign unused_load0 = load[0];

  // Sweep runs r1..r31; the counter is parked at 0 on exit so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            cnt   <= 5'd1;
          end
        end
        default: begin
          if (cnt == 5'd31) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
      endcase
    end
  end

  assign b[flat_idx(0, 0) +: WIDTH] = '0;

  for (genvar k = 1; k < NREG; k++) begin : g_reg
    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (load[k]) begin
        q <= load_data;
      end
    end

    assign b[flat_idx(k, 0) +: WIDTH] = q;
  end

endmodule

// File: tb/tb_regfile_bank.sv
// tb/tb_regfile_bank.sv - self-checking bench for regfile_bank
module tb_regfile_bank;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [4:0]    wa;
  logic [31:0]   wd;
  logic          clr;
  logic          busy;
  logic [1023:0] b;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [32];
  int          sweep_left;

  regfile_bank dut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .clr   (clr),
    .busy  (busy),
    .b     (b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  rk;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [31:0] get_reg(input int k);
    return b[k*32 +: 32];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 32; k++) mdl[k] = '0;
    sweep_left = 0;
  endtask

  // Sweep clears r1..r31 in order; while it runs the array ignores the CPU.
  task automatic model_edge();
    if (sweep_left > 0) begin
      mdl[32 - sweep_left] = '0;
      sweep_left--;
    end else begin
      if (we && wa != 5'd0) mdl[wa] = wd;
      if (clr) sweep_left = 31;
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name);
    int bad;
    bad = -1;
    for (int k = 31; k >= 0; k--) begin
      if (get_reg(k) !== mdl[k]) bad = k;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s image r%0d: got %h expected %h", name, bad, get_reg(bad), mdl[bad]);
    end
    checks++;
    if (busy !== (sweep_left > 0)) begin
      errors++;
      $display("FAIL %s busy: got %b expected %b", name, busy, (sweep_left > 0));
    end
  endtask

  task automatic cycle(input logic we_i, input logic [4:0] wa_i, input logic [31:0] wd_i,
                       input logic clr_i, input bit chk, input string name);
    we  = we_i;
    wa  = wa_i;
    wd  = wd_i;
    clr = clr_i;
    @(posedge clk);
    model_edge();
    #1;
    if (chk) check_all(name);
  endtask

  // Called at posedge+1: asserts reset between edges and checks without a clock.
  task automatic async_reset(input string name);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all(name);
    check_val({name, " r31"}, get_reg(31), 32'h0);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin : main
    int busy_cnt;
    int hit;

    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  32'hDEADBEEF};
    tbl[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h00000000};
    tbl[2] = '{1'b1, 5'd31, 32'h80000001, 5'd31, 32'h80000001};
    tbl[3] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  32'h00000001};
    tbl[4] = '{1'b0, 5'd9,  32'h11111111, 5'd9,  32'h00000000};
    tbl[5] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  32'hCAFEF00D};
    tbl[6] = '{1'b1, 5'd5,  32'h0BADC0DE, 5'd5,  32'h0BADC0DE};
    tbl[7] = '{1'b1, 5'd16, 32'hFFFFFFFF, 5'd5,  32'h0BADC0DE};

    rst_n = 1'b0;
    we = 1'b0; wa = '0; wd = '0; clr = 1'b0;
    model_clear();
    #12;
    check_all("reset");
    check_val("reset r0", get_reg(0), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].we, tbl[i].wa, tbl[i].wd, 1'b0, 1'b1, $sformatf("vec%0d", i));
      check_val($sformatf("vec%0d slice", i), get_reg(int'(tbl[i].rk)), tbl[i].exp);
    end

    async_reset("async reset loaded");

    // Full sweep over a preloaded array, with a dropped write to r3.
    for (int k = 1; k < 32; k++) cycle(1'b1, 5'(k), 32'hA5A5A5A5, 1'b0, 1'b0, "preload");
    check_all("preload");
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, "sweep start");
    busy_cnt = busy ? 1 : 0;
    for (int j = 1; j <= 32; j++) begin
      if (j == 3)       cycle(1'b1, 5'd3, 32'h1234, 1'b0, 1'b1, "sweep drop");
      else if (j == 32) cycle(1'b1, 5'd9, 32'h99, 1'b0, 1'b1, "post sweep write");
      else              cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "sweep");
      if (busy) busy_cnt++;
      if (j <= 31) check_val($sformatf("sweep r%0d cleared", j), get_reg(j), 32'h0);
      if (j < 31)  check_val($sformatf("sweep r%0d pending", j + 1), get_reg(j + 1), 32'hA5A5A5A5);
    end
    check_val("sweep busy cycles", 32'(busy_cnt), 32'd31);
    check_val("sweep r3 dropped", get_reg(3), 32'h0);
    check_val("post sweep r9", get_reg(9), 32'h99);

    // Write and clr in the same cycle: write lands, sweep erases it at N+7.
    cycle(1'b1, 5'd7, 32'h55, 1'b1, 1'b1, "collision");
    hit = (get_reg(7) == 32'h55) ? 1 : 0;
    for (int j = 1; j <= 31; j++) begin
      cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "collision sweep");
      if (get_reg(7) == 32'h55) hit++;
    end
    check_val("collision r7 cycles", 32'(hit), 32'd7);
    check_val("collision r7 end", get_reg(7), 32'h0);

    // Reset in the middle of a sweep.
    for (int k = 20; k < 32; k++) cycle(1'b1, 5'(k), $urandom, 1'b0, 1'b1, "mid preload");
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, "mid start");
    for (int j = 1; j < 10; j++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, "mid sweep");
    async_reset("reset mid sweep");
    cycle(1'b1, 5'd31, 32'hCAFE1234, 1'b0, 1'b1, "after reset write");
    check_val("after reset r31", get_reg(31), 32'hCAFE1234);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 39) == 0), 1'b1, $sformatf("random%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bank.md
# regfile_bank

Storage stage of the single-cycle CPU register file: 32 registers of 32 bits each, one synchronous write port, r0 hardwired to zero. The whole array is presented as one flat 1024-bit bus that feeds the downstream 1024-to-32 read multiplexer. A built-in clear sequencer zeroes the array one register per cycle on request, without needing a reset.

## Interface
Parameters:
- NREG, 32: number of registers. Fixed at 32; the downstream 5-bit select depends on it.
- WIDTH, 32: bits per register.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low. Clears all registers and returns the sequencer to IDLE.
- we  in  1  write enable.
- wa  in  5  write address.
- wd  in  32  write data.
- clr  in  1  starts a clear sweep. Sampled only in IDLE.
- busy  out  1  high while the clear sweep runs.
- b  out  1024  flat register image. Register k occupies b[32k+31:32k], so bit i of register k is b[32k+i].

## Operation
Write port:
- When we=1 and wa≠0 in IDLE, wd is stored into reg[wa] at the rising edge.
- Writes with wa=0 are ignored. b[31:0] is constant 0.

Sequencer states and transitions:
- IDLE → CLEAR when clr=1. On that edge the sweep counter is loaded with 1.
- CLEAR, each cycle: reg[cnt] ← 0, then cnt ← cnt+1.
- CLEAR → IDLE on the edge that clears reg[31]. The 5-bit counter never wraps.

Rules during CLEAR:
- Writes (we=1) are dropped. The CPU must stall on busy.
- clr is ignored.

Simultaneous events:
- we and clr together in IDLE: the write is performed on that edge, and the sweep starts. The written register is later zeroed by the sweep.

Reset:
- rst_n low at any time, including mid-sweep: all registers go to 0, state goes to IDLE, cnt goes to 0, busy goes to 0, immediately and without waiting for a clock edge.
- Deassertion is synchronised externally.

Output behaviour:
- b is purely registered. There is no write-to-read bypass.
- busy is decoded from the state register, so it is glitch-free.

## Timing
- Reset values: b = all zero, busy = 0.
- Write latency: a write at edge N is visible on b after edge N, i.e. it is read in cycle N+1.
- Clear sweep: clr sampled at edge N → busy=1 from after edge N through edge N+31. busy=0 after edge N+31.
  - Total sweep: 31 cycles (r1..r31).
  - Register k reads 0 after edge N+k.
- Earliest accepted write after a sweep: edge N+32.
- Back-to-back writes to the same address: the last write wins. One write per cycle.

## Structure
Shared package rf_pkg:
- constants NREG=32, WIDTH=32, AW=5.
- sequencer state encoding: IDLE=1'b0, CLEAR=1'b1.
- helper for the flat-bus slice index (32k+i).

Sub-module decoder5to32:
- 5-bit address plus enable in, 32-bit one-hot load-enable out.
- bit 0 is forced low.
- Shared by the write path and the sweep path: address and enable are multiplexed by state.

Top-level contents:
- 31 WIDTH-bit registers with async clear.
- state flop and 5-bit counter.
- concatenation onto b.

## Test plan
- Reset: drive rst_n=0 mid-cycle after loading values → b=0 and busy=0 immediately, with no clock edge.
- Write/read: we=1, wa=5, wd=32'hDEADBEEF → b[191:160]=32'hDEADBEEF after the edge; every other slice unchanged.
- r0 protection: we=1, wa=0, wd=32'hFFFFFFFF → b[31:0] stays 0.
- Sweep:
  - Preload all registers with 32'hA5A5A5A5, then pulse clr at edge N.
  - busy is high for exactly 31 cycles.
  - reg[k] clears after edge N+k.
  - A write of 32'h1234 to r3 during busy is dropped: r3 reads 0 at the end.
- Collision: we=1, wa=7, wd=32'h55 with clr=1 in the same cycle → r7 reads 32'h55 for 7 cycles, then reads 0.
- Reset mid-sweep: rst_n=0 at sweep cycle 10 → busy=0 and all registers 0. After release, the block is IDLE and a write to r31 succeeds on the next edge.
